// File: rtl/branch_predict_ctrl.sv
// Branch predictor controller: turns BTB reads into fetch predictions and
// applies queued branch resolutions as read-modify-write updates of the BTB.
module branch_predict_ctrl #(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned IDX_W      = 4
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic                fetch_valid,
    input  logic                fetch_stall,
    input  logic [31:0]         fetch_pc,
    output logic                pred_used,
    output logic                pred_taken,
    output logic [31:0]         pred_target,
    input  logic                upd_valid,
    input  logic [31:0]         upd_pc,
    input  logic [31:0]         upd_target,
    input  logic                upd_taken,
    input  logic                upd_mispred,
    output logic                upd_ready,
    output logic [29:0]         rsel,
    output logic [29:0]         wsel,
    output logic                wen,
    output logic [64-IDX_W:0]   wdat,
    output logic                phit,
    input  logic [64-IDX_W:0]   rdat,
    output logic                busy,
    output logic [15:0]         ovf_cnt
);

    localparam int unsigned TAG_W      = 30 - IDX_W;
    localparam logic [3:0]  STARVE_LIM = 4'(STARVE_MAX);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RD   = 2'd2;
    localparam logic [1:0] S_WR   = 2'd3;

    typedef struct packed {
        logic             v;
        logic [TAG_W-1:0] tag;
        logic [31:0]      tgt;
        logic [1:0]       cnt;
    } frame_t;

    logic [1:0]  state_q, state_d;
    logic [3:0]  starve_q, starve_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        head_q;
    logic [15:0] ovf_q;
    frame_t      frame_q;

    logic [29:0] q_sel_q [2];
    logic [31:0] q_tgt_q [2];
    logic        q_tkn_q [2];
    logic        q_mis_q [2];

    logic        push, drop, pop, tail;
    logic [29:0] hd_sel;
    frame_t      rd_frame, new_frame;
    logic        rd_hit, fr_hit;

    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{fetch_pc[1:0], upd_pc[1:0]};

    assign hd_sel   = q_sel_q[head_q];
    assign tail     = head_q ^ cnt_q[0];
    assign rsel     = (state_q == S_RD) ? hd_sel : fetch_pc[31:2];
    assign rd_frame = rdat;
    assign rd_hit   = rd_frame.v && (rd_frame.tag == rsel[29:IDX_W]);

    assign pred_used   = (state_q != S_RD) && fetch_valid && !fetch_stall;
    assign pred_taken  = pred_used && rd_hit && rd_frame.cnt[1];
    assign pred_target = pred_taken ? rd_frame.tgt : '0;

    assign upd_ready = (cnt_q != 2'd2);
    assign busy      = (cnt_q != 2'd0) || (state_q != S_IDLE);
    assign ovf_cnt   = ovf_q;

    // Hit is judged against the frame captured in RD; the BTB read in WR belongs to fetch.
    assign fr_hit = frame_q.v && (frame_q.tag == hd_sel[29:IDX_W]);

    always_comb begin
        new_frame = frame_q;
        if (fr_hit) begin
            if (q_tkn_q[head_q]) begin
                if (frame_q.cnt != 2'd3) new_frame.cnt = frame_q.cnt + 2'd1;
                new_frame.tgt = q_tgt_q[head_q];
            end else if (frame_q.cnt != 2'd0) begin
                new_frame.cnt = frame_q.cnt - 2'd1;
            end
        end else begin
            new_frame = '{v: 1'b1, tag: hd_sel[29:IDX_W], tgt: q_tgt_q[head_q], cnt: 2'b10};
        end
    end

    assign wen  = (state_q == S_WR) && (fr_hit || q_tkn_q[head_q]);
    assign phit = wen && !q_mis_q[head_q];
    assign wsel = (state_q == S_WR) ? hd_sel : '0;
    assign wdat = wen ? new_frame : '0;

    always_comb begin
        push     = upd_valid && (cnt_q != 2'd2);
        drop     = upd_valid && (cnt_q == 2'd2);
        pop      = (state_q == S_WR);
        cnt_d    = cnt_q + 2'(push) - 2'(pop);
        state_d  = state_q;
        starve_d = starve_q;
        case (state_q)
            S_IDLE: begin
                if (cnt_d != 2'd0) begin
                    state_d  = S_WAIT;
                    starve_d = '0;
                end
            end
            S_WAIT: begin
                if (!fetch_valid || fetch_stall || (starve_q >= STARVE_LIM)) begin
                    state_d = S_RD;
                end else begin
                    starve_d = starve_q + 4'd1;
                end
            end
            S_RD: state_d = S_WR;
            default: begin
                starve_d = '0;
                state_d  = (cnt_d != 2'd0) ? S_WAIT : S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q  <= S_IDLE;
            starve_q <= '0;
            cnt_q    <= '0;
            head_q   <= 1'b0;
            ovf_q    <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            cnt_q    <= cnt_d;
            head_q   <= head_q ^ pop;
            if (drop && (ovf_q != '1)) ovf_q <= ovf_q + 16'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            q_sel_q[tail] <= upd_pc[31:2];
            q_tgt_q[tail] <= upd_target;
            q_tkn_q[tail] <= upd_taken;
            q_mis_q[tail] <= upd_mispred;
        end
        if (state_q == S_RD) frame_q <= rd_frame;
    end

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Directed bench for branch_predict_ctrl with a small behavioural BTB model.
module tb_branch_predict_ctrl;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        fetch_valid, fetch_stall;
    logic [31:0] fetch_pc;
    logic        pred_used, pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid, upd_taken, upd_mispred;
    logic [31:0] upd_pc, upd_target;
    logic        upd_ready;
    logic [29:0] rsel, wsel;
    logic        wen, phit, busy;
    logic [60:0] wdat, rdat;
    logic [15:0] ovf_cnt;

    always #5 CLK = ~CLK;

    branch_predict_ctrl #(.STARVE_MAX(4), .IDX_W(4)) dut (
        .CLK(CLK), .nRST(nRST),
        .fetch_valid(fetch_valid), .fetch_stall(fetch_stall), .fetch_pc(fetch_pc),
        .pred_used(pred_used), .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target),
        .upd_taken(upd_taken), .upd_mispred(upd_mispred), .upd_ready(upd_ready),
        .rsel(rsel), .wsel(wsel), .wen(wen), .wdat(wdat), .phit(phit),
        .rdat(rdat), .busy(busy), .ovf_cnt(ovf_cnt)
    );

    // 16-entry BTB indexed by the low select bits
    logic [60:0] btb [16];
    logic        btb_clr;
    always @(posedge CLK) begin
        if (btb_clr) begin
            for (int i = 0; i < 16; i++) btb[i] <= '0;
        end else if (wen) begin
            btb[wsel[3:0]] <= wdat;
        end
    end
    assign rdat = btb[rsel[3:0]];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge CLK);
        #1;
    endtask

    task automatic run_upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                           input logic mis, output int wc, output logic [60:0] wd,
                           output logic ph);
        wc = 0; wd = '0; ph = 1'b0;
        fetch_valid = 1'b1; fetch_stall = 1'b1; fetch_pc = 32'h200;
        upd_valid = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tgt; upd_mispred = mis;
        nxt();
        upd_valid = 1'b0;
        for (int i = 0; i < 30; i++) begin
            #2;
            if (wen) begin
                wc++; wd = wdat; ph = phit;
            end
            if (!busy) break;
            nxt();
        end
        chk("drain_busy", busy, 0);
    endtask

    localparam logic [60:0] F_COLD  = {1'b1, 26'd1, 32'h100, 2'b10};
    localparam logic [60:0] F_STARV = {1'b1, 26'd1, 32'h200, 2'b10};

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int          wc, nlow, first, wk;
        logic [60:0] wd;
        logic        ph;
        int unsigned exp_cnt [7] = '{3, 3, 3, 2, 1, 0, 0};
        logic        exp_pt  [7] = '{1, 1, 1, 1, 0, 0, 0};

        nRST = 1'b0; btb_clr = 1'b1;
        fetch_valid = 1'b0; fetch_stall = 1'b0; fetch_pc = '0;
        upd_valid = 1'b0; upd_pc = '0; upd_target = '0; upd_taken = 1'b0; upd_mispred = 1'b0;
        nxt(); nxt(); #2;
        chk("rst_ready", upd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_wen", wen, 0);
        chk("rst_phit", phit, 0);
        chk("rst_ovf", ovf_cnt, 0);
        nRST = 1'b1; btb_clr = 1'b0;

        // Cold miss, taken: wen lands in the third cycle after enqueue
        fetch_valid = 1'b1; fetch_stall = 1'b1; fetch_pc = 32'h200;
        nxt();
        upd_valid = 1'b1; upd_pc = 32'h40; upd_taken = 1'b1; upd_target = 32'h100; upd_mispred = 1'b1;
        #2; chk("c0_pred_used", pred_used, 0);
        nxt(); upd_valid = 1'b0; #2;
        chk("c1_wen", wen, 0);
        chk("c1_busy", busy, 1);
        nxt(); #2;
        chk("c2_wen", wen, 0);
        chk("c2_rsel", rsel, 30'h10);
        nxt(); #2;
        chk("c3_wen", wen, 1);
        chk("c3_wdat", wdat, F_COLD);
        chk("c3_wsel", wsel, 30'h10);
        chk("c3_phit", phit, 0);
        nxt(); fetch_stall = 1'b0; fetch_pc = 32'h40; #2;
        chk("c4_busy", busy, 0);
        chk("c4_pred_used", pred_used, 1);
        chk("c4_pred_taken", pred_taken, 1);
        chk("c4_pred_target", pred_target, 32'h100);

        // Saturation: three taken then four not-taken updates on the same branch
        for (int i = 0; i < 7; i++) begin
            nxt();
            run_upd(32'h40, (i < 3), 32'h100, 1'b0, wc, wd, ph);
            chk("sat_wen", wc, 1);
            chk("sat_cnt", wd[1:0], exp_cnt[i]);
            chk("sat_phit", ph, 1);
            nxt(); fetch_stall = 1'b0; fetch_pc = 32'h40; #2;
            chk("sat_pred_taken", pred_taken, exp_pt[i]);
            chk("sat_pred_target", pred_target, exp_pt[i] ? 32'h100 : 32'h0);
        end

        // Miss, not taken: nothing is written
        nxt();
        run_upd(32'h80, 1'b0, 32'h999, 1'b0, wc, wd, ph);
        chk("mnt_wen", wc, 0);
        chk("mnt_phit", ph, 0);

        // Starvation: fetch never yields, port is stolen after five WAIT cycles
        nxt();
        fetch_valid = 1'b1; fetch_stall = 1'b0; fetch_pc = 32'h300;
        upd_valid = 1'b1; upd_pc = 32'h44; upd_taken = 1'b1; upd_target = 32'h200; upd_mispred = 1'b1;
        #2;
        nxt(); upd_valid = 1'b0;
        nlow = 0; first = 0; wk = 0; wd = '0; ph = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            #2;
            if (!pred_used) begin
                nlow++;
                if (first == 0) first = k;
            end
            if (wen) begin
                wk = k; wd = wdat; ph = phit;
            end
            nxt();
        end
        chk("starve_low_cycles", nlow, 1);
        chk("starve_rd_cycle", first, 6);
        chk("starve_wen_cycle", wk, 7);
        chk("starve_wdat", wd, F_STARV);
        chk("starve_phit", ph, 0);

        // Overflow: three back-to-back updates while fetch holds the port
        upd_valid = 1'b1; upd_pc = 32'h48; upd_taken = 1'b1; upd_target = 32'h500; upd_mispred = 1'b0;
        #2; chk("ovf_ready0", upd_ready, 1);
        nxt(); upd_pc = 32'h4C; upd_target = 32'h504; #2;
        chk("ovf_ready1", upd_ready, 1);
        nxt(); upd_pc = 32'h50; upd_target = 32'h508; #2;
        chk("ovf_ready2", upd_ready, 0);
        nxt(); upd_valid = 1'b0; #2;
        chk("ovf_cnt", ovf_cnt, 1);
        chk("ovf_ready3", upd_ready, 0);
        fetch_stall = 1'b1;
        wc = 0;
        for (int k = 0; k < 40; k++) begin
            if (wen) wc++;
            if (!busy) break;
            nxt(); #2;
        end
        chk("ovf_drain_busy", busy, 0);
        chk("ovf_writes", wc, 2);
        chk("ovf_dropped_unwritten", btb[4][60], 0);

        // Reset while the update FSM owns the read port
        nxt();
        fetch_valid = 1'b1; fetch_stall = 1'b1; fetch_pc = 32'h200;
        upd_valid = 1'b1; upd_pc = 32'h58; upd_taken = 1'b1; upd_target = 32'h600; upd_mispred = 1'b0;
        #2;
        nxt(); upd_valid = 1'b0; #2;
        chk("mrst_busy_pre", busy, 1);
        nxt(); #2;
        chk("mrst_rsel", rsel, 30'h16);
        nRST = 1'b0;
        nxt(); #2;
        chk("mrst_wen", wen, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_ready", upd_ready, 1);
        chk("mrst_phit", phit, 0);
        nRST = 1'b1;
        wc = 0;
        for (int k = 0; k < 8; k++) begin
            nxt(); #2;
            if (wen) wc++;
        end
        chk("mrst_no_write", wc, 0);
        chk("mrst_btb_clean", btb[6][60], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
